posit_add_pipe: RTL and testbench
=================================

POSIT_ADD_PIPE -- requirements
Module: posit_add_pipe

Interface
REQ-001 Parameters SHALL be: N, default 16, posit width; MW, default N-4, fraction width; SFW, default N-10, signed scale-factor width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  clock, all state on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  i_valid  in  1  input operand pair valid
  o_ready  out  1  block can accept input this cycle
  i_op  in  1  0 = X+Y, 1 = X-Y
  i_s_1, i_s_2  in  1  operand sign
  i_sf_1, i_sf_2  in  SFW  signed scale factor
  i_mant_1, i_mant_2  in  MW  fraction bits
  i_nzn_1, i_nzn_2  in  1  1 = nonzero, not NaR
  o_valid  out  1  result valid
  i_ready  in  1  downstream accepts result
  o_s  out  1  result sign
  o_sf  out  SFW+1  signed result scale factor
  o_mant  out  MW  result fraction
  o_guard  out  1  first bit below o_mant
  o_sticky  out  1  OR of all bits below guard
  o_nzn  out  1  result nonzero and not NaR
REQ-003 Clock and reset SHALL be one clock, clk; reset rst_n, asynchronous, active-low.

Function
REQ-004 Operand decode: s=0,nzn=0 is zero; s=1,nzn=0 is NaR; value = (-2*s + h + mant/2^MW)*2^sf, h = ~s & nzn.
REQ-005 Significand SHALL be {s, h, mant}, sign-extended to MW+3 bits; i_op=1 SHALL two's-complement-negate operand 2's significand at that width before any comparison of magnitude.
REQ-006 Pipeline SHALL be 3 stages: S1 align (compare sf, swap, right-shift smaller significand with sign padding, capture guard/round/sticky), S2 add at MW+4 bits, S3 normalise (leading sign-bit count) and pack.
REQ-007 Larger operand SHALL be the one with strictly greater signed sf; on equal sf, operand 1 is larger.
REQ-008 Shift amount SHALL be sf_large - sf_small computed at SFW+1 bits; amounts >= MW+4 SHALL saturate to MW+4, all shifted-out bits ORed into sticky.
REQ-009 o_sf SHALL equal sf_large + 1 - lead_count at SFW+1 bits, lead_count = redundant sign bits of sum.
REQ-010 o_mant SHALL be the MW bits following the normalised sign and hidden bit; o_guard next bit; o_sticky OR of round, sticky and all remaining bits.
REQ-011 Exact zero sum (all sum, guard, round, sticky bits zero) SHALL give o_nzn=0, o_s=0, o_sf=0, o_mant=0, o_guard=0, o_sticky=0.
REQ-012 Either operand NaR SHALL give o_s=1, o_nzn=0, other fields don't-care; NaR flag SHALL propagate with its stage, unaffected by i_op.
REQ-013 Zero operand SHALL have significand 0 and take part in alignment as a normal value.
REQ-014 Handshake: stage advance en = ~o_valid | i_ready; o_ready = en; input captured when i_valid & o_ready.
REQ-015 Latency SHALL be 3 cycles from accepted input to o_valid with i_ready held 1; throughput one result per cycle.
REQ-016 With o_valid=1 and i_ready=0, all stages and all outputs SHALL hold unchanged.
REQ-017 Per-stage valid bits SHALL travel with data; bubbles SHALL be compressed only via REQ-014 (no internal bubble collapse).

Reset
REQ-018 rst_n=0 SHALL immediately clear all stage valid bits and o_valid, and drive o_s, o_sf, o_mant, o_guard, o_sticky, o_nzn to 0; o_ready SHALL be 1 during and after reset.
REQ-019 Reset during operation SHALL discard in-flight operations; no result from pre-reset input SHALL appear afterwards.

Verification
REQ-020 N=16, 1.0+1.0 (s=0, sf=0, mant=0, nzn=1 both, i_op=0) -> 3 cycles later o_valid=1, o_s=0, o_sf=1, o_mant=0, guard=0, sticky=0, o_nzn=1.
REQ-021 1.5-1.5 (mant=0x800, sf=0, i_op=1) -> o_nzn=0, o_s=0, all fields 0.
REQ-022 1.0-0.5 (Y: sf=-1, mant=0, i_op=1) -> o_s=0, o_sf=-1, o_mant=0, o_nzn=1.
REQ-023 1.0+2^-20 (Y: sf=-20, mant=0) -> shift saturates; o_sf=0, o_mant=0, guard=0, sticky=1.
REQ-024 NaR+1.0 -> o_s=1, o_nzn=0; 8 back-to-back inputs with i_ready toggled 1010... -> results in order, none lost or duplicated, outputs stable while i_ready=0.
REQ-025 rst_n pulsed low with 3 operations in flight -> o_valid=0 at once and no stale result after release.

Source files
------------

// File: rtl/posit_add_pipe.sv
// posit_add_pipe: three-stage posit-style significand adder (align, add, normalise/pack)
// with valid/ready flow control; operands and result are in decoded sign/scale/fraction form.
module posit_add_pipe #(
  parameter int N   = 16,
  parameter int MW  = N - 4,
  parameter int SFW = N - 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic           i_op,
  input  logic           i_s_1,
  input  logic           i_s_2,
  input  logic [SFW-1:0] i_sf_1,
  input  logic [SFW-1:0] i_sf_2,
  input  logic [MW-1:0]  i_mant_1,
  input  logic [MW-1:0]  i_mant_2,
  input  logic           i_nzn_1,
  input  logic           i_nzn_2,
  output logic           o_valid,
  input  logic           i_ready,
  output logic           o_s,
  output logic [SFW:0]   o_sf,
  output logic [MW-1:0]  o_mant,
  output logic           o_guard,
  output logic           o_sticky,
  output logic           o_nzn
);
  localparam int W  = MW + 3;
  localparam int A  = MW + 4;
  localparam int E  = MW + 6;
  localparam int LW = $clog2(E);

  logic                 w_en;
  logic [W-1:0]         w_sig1, w_sig2, w_sig2n, w_big, w_sml;
  logic                 w_swap, w_nar;
  logic [SFW-1:0]       w_sfl, w_sfs;
  logic [SFW:0]         w_d, w_sh;
  logic signed [W+A-1:0] w_al;

  logic                 r1_v, r1_nar;
  logic [W-1:0]         r1_big, r1_sml;
  logic [2:0]           r1_grs;
  logic [SFW-1:0]       r1_sf;

  logic                 r2_v, r2_nar;
  logic [A-1:0]         r2_sum;
  logic [2:0]           r2_grs;
  logic [SFW-1:0]       r2_sf;

  logic [E-1:0]         w_nx;
  logic [E-3:0]         w_fr;
  logic [LW-1:0]        w_lc;
  logic                 w_run, w_zero, w_clr;
  logic [SFW:0]         w_osf;

  assign w_en    = ~o_valid | i_ready;
  assign o_ready = w_en;

  // Zero and NaR carry a zero significand; hidden bit is ~s for nonzero values
  assign w_sig1  = i_nzn_1 ? {i_s_1, i_s_1, ~i_s_1, i_mant_1} : '0;
  assign w_sig2  = i_nzn_2 ? {i_s_2, i_s_2, ~i_s_2, i_mant_2} : '0;
  assign w_sig2n = i_op ? -w_sig2 : w_sig2;
  assign w_nar   = (i_s_1 & ~i_nzn_1) | (i_s_2 & ~i_nzn_2);
  assign w_swap  = $signed(i_sf_2) > $signed(i_sf_1);
  assign w_big   = w_swap ? w_sig2n : w_sig1;
  assign w_sml   = w_swap ? w_sig1 : w_sig2n;
  assign w_sfl   = w_swap ? i_sf_2 : i_sf_1;
  assign w_sfs   = w_swap ? i_sf_1 : i_sf_2;
  assign w_d     = {w_sfl[SFW-1], w_sfl} - {w_sfs[SFW-1], w_sfs};
  assign w_sh    = (w_d >= (SFW+1)'(A)) ? (SFW+1)'(A) : w_d;
  // Smaller significand is shifted into an A-bit tail so nothing is lost before sticky folding
  assign w_al    = $signed({w_sml, {A{1'b0}}}) >>> w_sh;

  // Large operand has an all-zero tail, so guard/round/sticky pass through the add untouched
  assign w_nx = {r2_sum[W-1:0], r2_grs};

  always_comb begin
    w_lc  = '0;
    w_run = 1'b1;
    for (int i = E - 2; i >= 0; i--) begin
      w_run = w_run & (w_nx[i] == w_nx[E-1]);
      w_lc  = w_lc + LW'(w_run);
    end
  end

  assign w_fr   = w_nx[E-3:0] << w_lc;
  assign w_zero = ~|{r2_sum, r2_grs};
  assign w_clr  = r2_nar | w_zero;
  assign w_osf  = {r2_sf[SFW-1], r2_sf} + (SFW+1)'(1) - (SFW+1)'(w_lc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v     <= 1'b0;
      r1_nar   <= 1'b0;
      r1_big   <= '0;
      r1_sml   <= '0;
      r1_grs   <= '0;
      r1_sf    <= '0;
      r2_v     <= 1'b0;
      r2_nar   <= 1'b0;
      r2_sum   <= '0;
      r2_grs   <= '0;
      r2_sf    <= '0;
      o_valid  <= 1'b0;
      o_s      <= 1'b0;
      o_sf     <= '0;
      o_mant   <= '0;
      o_guard  <= 1'b0;
      o_sticky <= 1'b0;
      o_nzn    <= 1'b0;
    end else if (w_en) begin
      r1_v     <= i_valid;
      r1_nar   <= w_nar;
      r1_big   <= w_big;
      r1_sml   <= w_al[W+A-1:A];
      r1_grs   <= {w_al[A-1], w_al[A-2], |w_al[A-3:0]};
      r1_sf    <= w_sfl;
      r2_v     <= r1_v;
      r2_nar   <= r1_nar;
      r2_sum   <= {r1_big[W-1], r1_big} + {r1_sml[W-1], r1_sml};
      r2_grs   <= r1_grs;
      r2_sf    <= r1_sf;
      o_valid  <= r2_v;
      o_s      <= r2_nar | (~w_zero & r2_sum[A-1]);
      o_nzn    <= ~w_clr;
      o_sf     <= w_clr ? '0 : w_osf;
      o_mant   <= w_clr ? '0 : w_fr[E-3:4];
      o_guard  <= ~w_clr & w_fr[3];
      o_sticky <= ~w_clr & (|w_fr[2:0]);
    end
  end
endmodule

// File: tb/tb_posit_add_pipe.sv
// tb_posit_add_pipe: directed vectors with hand-computed results, queued scoreboard
// checked by an independent output monitor, plus hold-stability and reset-flush checks.
module tb_posit_add_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0, i_op = 1'b0;
  logic        i_s_1 = 1'b0, i_s_2 = 1'b0, i_nzn_1 = 1'b0, i_nzn_2 = 1'b0;
  logic [5:0]  i_sf_1 = '0, i_sf_2 = '0;
  logic [11:0] i_mant_1 = '0, i_mant_2 = '0;
  logic        i_ready = 1'b1;
  logic        o_ready, o_valid, o_s, o_guard, o_sticky, o_nzn;
  logic [6:0]  o_sf;
  logic [11:0] o_mant;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;

  typedef struct {
    logic op, s1, n1, s2, n2;
    logic [5:0] sf1, sf2;
    logic [11:0] m1, m2;
    logic es, eg, est, enz, nar;
    logic [6:0] esf;
    logic [11:0] em;
  } vec_t;

  typedef struct {
    vec_t v;
    int   id;
    int   t;
    bit   lat;
  } exp_t;

  vec_t vecs[$];
  exp_t q[$];

  posit_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_s_1(i_s_1), .i_s_2(i_s_2), .i_sf_1(i_sf_1), .i_sf_2(i_sf_2),
    .i_mant_1(i_mant_1), .i_mant_2(i_mant_2), .i_nzn_1(i_nzn_1), .i_nzn_2(i_nzn_2),
    .o_valid(o_valid), .i_ready(i_ready), .o_s(o_s), .o_sf(o_sf), .o_mant(o_mant),
    .o_guard(o_guard), .o_sticky(o_sticky), .o_nzn(o_nzn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: always ready, 1: toggle every cycle, 2: stalled
  always @(posedge clk) begin
    #1;
    i_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~i_ready : 1'b0;
  end

  function automatic vec_t mk(logic op, logic s1, int sf1, logic [11:0] m1, logic n1,
                              logic s2, int sf2, logic [11:0] m2, logic n2,
                              logic es, int esf, logic [11:0] em, logic eg, logic est,
                              logic enz, logic nar);
    vec_t r;
    r.op = op; r.s1 = s1; r.sf1 = 6'(sf1); r.m1 = m1; r.n1 = n1;
    r.s2 = s2; r.sf2 = 6'(sf2); r.m2 = m2; r.n2 = n2;
    r.es = es; r.esf = 7'(esf); r.em = em; r.eg = eg; r.est = est; r.enz = enz; r.nar = nar;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic send(input int id, input bit lat, input bit push);
    vec_t v;
    exp_t e;
    int t;
    v = vecs[id];
    t = 0;
    i_op = v.op; i_s_1 = v.s1; i_sf_1 = v.sf1; i_mant_1 = v.m1; i_nzn_1 = v.n1;
    i_s_2 = v.s2; i_sf_2 = v.sf2; i_mant_2 = v.m2; i_nzn_2 = v.n2;
    i_valid = 1'b1;
    while (!o_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout id=%0d o_ready=%b required=1", id, o_ready);
    end else if (push) begin
      e.v = v; e.id = id; e.t = cyc; e.lat = lat;
      q.push_back(e);
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  bit          held = 0;
  logic [22:0] hv;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      if (held) begin
        checks++;
        if (o_valid !== 1'b1 || {o_s, o_sf, o_mant, o_guard, o_sticky, o_nzn} !== hv) begin
          errors++;
          $display("FAIL hold_stable got=%b/%h required=1/%h", o_valid,
                   {o_s, o_sf, o_mant, o_guard, o_sticky, o_nzn}, hv);
        end
      end
      held = o_valid & ~i_ready;
      hv = {o_s, o_sf, o_mant, o_guard, o_sticky, o_nzn};
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got o_valid=1 required no result");
        end else begin
          me = q.pop_front();
          checks++;
          if (me.v.nar ? ({o_s, o_nzn} !== 2'b10) :
              ({o_s, o_sf, o_mant, o_guard, o_sticky, o_nzn} !==
               {me.v.es, me.v.esf, me.v.em, me.v.eg, me.v.est, me.v.enz})) begin
            errors++;
            $display("FAIL result id=%0d got s=%b sf=%0d mant=%h g=%b st=%b nzn=%b required s=%b sf=%0d mant=%h g=%b st=%b nzn=%b nar=%b",
                     me.id, o_s, $signed(o_sf), o_mant, o_guard, o_sticky, o_nzn,
                     me.v.es, $signed(me.v.esf), me.v.em, me.v.eg, me.v.est, me.v.enz, me.v.nar);
          end
          if (me.lat) begin
            checks++;
            if (cyc - me.t != 3) begin
              errors++;
              $display("FAIL latency id=%0d got=%0d required=3", me.id, cyc - me.t);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(0, 0,   0, 12'h000, 1, 0,   0, 12'h000, 1, 0,   1, 12'h000, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,   0, 12'h800, 1, 0,   0, 12'h800, 1, 0,   0, 12'h000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,   0, 12'h000, 1, 0,  -1, 12'h000, 1, 0,  -1, 12'h000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,   0, 12'h000, 1, 0, -20, 12'h000, 1, 0,   0, 12'h000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 1,   0, 12'h000, 0, 0,   0, 12'h000, 1, 1,   0, 12'h000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0,   0, 12'h000, 1, 0,  -1, 12'h000, 1, 0,   0, 12'h800, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0,  -1, 12'h000, 1, 0,   0, 12'h000, 1, 1,  -2, 12'h000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,   5, 12'h000, 0, 0,   0, 12'h000, 1, 0,   0, 12'h000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,   0, 12'h000, 1, 1,   0, 12'h800, 1, 1,  -2, 12'h000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,   0, 12'h000, 1, 0, -13, 12'h000, 1, 0,   0, 12'h000, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0,   0, 12'h000, 1, 0, -12, 12'h000, 1, 0,   0, 12'h001, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,   0, 12'h000, 1, 0, -14, 12'h000, 1, 0,   0, 12'h000, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0,   0, 12'hC00, 1, 0,   0, 12'hC00, 1, 0,   1, 12'hC00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,   0, 12'h000, 1, 0,   0, 12'h001, 1, 0,   1, 12'h000, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0,   0, 12'h000, 1, 1,   0, 12'h000, 0, 1,   0, 12'h000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, -30, 12'h000, 1, 0, -30, 12'h000, 1, 0, -29, 12'h000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0,  31, 12'h000, 1, 0,  31, 12'h000, 1, 0,  32, 12'h000, 0, 0, 1, 0));

    repeat (3) @(negedge clk);
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_ready", o_ready, 1);
    chk("reset_outputs", {o_s, o_sf, o_mant, o_guard, o_sticky, o_nzn}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_o_ready", o_ready, 1);

    mode = 0;
    for (int i = 0; i < vecs.size(); i++) send(i, 1, 1);
    drain();

    mode = 1;
    for (int i = 0; i < vecs.size(); i++) send(i, 0, 1);
    drain();

    mode = 2;
    repeat (2) @(negedge clk);
    send(0, 0, 0);
    send(5, 0, 0);
    send(12, 0, 0);
    chk("stalled_o_valid", o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("flush_o_valid", o_valid, 0);
    chk("flush_o_ready", o_ready, 1);
    chk("flush_outputs", {o_s, o_sf, o_mant, o_guard, o_sticky, o_nzn}, 0);
    mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_stale_o_valid", o_valid, 0);

    send(3, 1, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
